// File: rtl/init_seq_pkg.sv
// Shared types and defaults for the init/reset sequencer.
// Sizing helper keeps every counter at least one bit wide.
package init_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_POR  = 3'd0,
    S_INIT = 3'd1,
    S_LOCK = 3'd2,
    S_HOLD = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_LOCK_FILTER    = 4;
  localparam int DEF_RELEASE_CYCLES = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1048576;
  localparam int DEF_REQUIRE_SRAM   = 1;
  localparam int DEF_REQUIRE_XCVR   = 0;

  // Bit positions inside the synchronised input vector.
  localparam int IDX_POR   = 0;
  localparam int IDX_DEV   = 1;
  localparam int IDX_SRAM  = 2;
  localparam int IDX_USRAM = 3;
  localparam int IDX_XCVR  = 4;
  localparam int IDX_PLL   = 5;
  localparam int IDX_EXT   = 6;
  localparam int N_SYNC    = 7;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/init_sync.sv
// Multi-bit, multi-stage flop synchroniser into the fabric clock.
// Each bit is an independent level; no bus coherency is implied.
module init_sync
  import init_seq_pkg::*;
#(
  parameter int W      = 7,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++)
        r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++)
        r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/init_reset_sequencer.sv
// Qualifies init-monitor flags and PLL lock, then releases a counted
// fabric reset; an init that never completes latches a sticky error.
module init_reset_sequencer
  import init_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
  parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int REQUIRE_SRAM   = DEF_REQUIRE_SRAM,
  parameter int REQUIRE_XCVR   = DEF_REQUIRE_XCVR
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               FABRIC_POR_N,
  input  logic               DEVICE_INIT_DONE,
  input  logic               SRAM_INIT_DONE,
  input  logic               USRAM_INIT_DONE,
  input  logic               XCVR_INIT_DONE,
  input  logic               PLL_LOCK,
  input  logic               EXT_RST_N,
  output logic               FABRIC_RESET_N,
  output logic               INIT_ERR,
  output logic [STATE_W-1:0] STATE
);

  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam int LW = cnt_w(LOCK_FILTER);
  localparam int RW = cnt_w(RELEASE_CYCLES);

  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LMAX = LW'(LOCK_FILTER - 1);
  localparam logic [RW-1:0] RMAX = RW'(RELEASE_CYCLES - 1);

  localparam logic REQ_SRAM = (REQUIRE_SRAM != 0);
  localparam logic REQ_XCVR = (REQUIRE_XCVR != 0);

  logic [N_SYNC-1:0] w_async;
  logic [N_SYNC-1:0] w_sync;

  logic w_por_s;
  logic w_init_ok;
  logic w_qual;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_nstate;
  logic [TW-1:0]      r_tmo;
  logic [TW-1:0]      w_tmo;
  logic [LW-1:0]      r_lock;
  logic [LW-1:0]      w_lock;
  logic [RW-1:0]      r_rel;
  logic [RW-1:0]      w_rel;
  logic               r_rst_n;
  logic               r_err;

  always_comb begin
    w_async            = '0;
    w_async[IDX_POR]   = FABRIC_POR_N;
    w_async[IDX_DEV]   = DEVICE_INIT_DONE;
    w_async[IDX_SRAM]  = SRAM_INIT_DONE;
    w_async[IDX_USRAM] = USRAM_INIT_DONE;
    w_async[IDX_XCVR]  = XCVR_INIT_DONE;
    w_async[IDX_PLL]   = PLL_LOCK;
    w_async[IDX_EXT]   = EXT_RST_N;
  end

  init_sync #(
    .W      (N_SYNC),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (w_async),
    .o_q   (w_sync)
  );

  assign w_por_s   = w_sync[IDX_POR];
  assign w_qual    = w_sync[IDX_PLL] & w_sync[IDX_EXT];
  assign w_init_ok = w_sync[IDX_DEV]
                   & (~REQ_SRAM | (w_sync[IDX_SRAM] & w_sync[IDX_USRAM]))
                   & (~REQ_XCVR | w_sync[IDX_XCVR]);

  always_comb begin
    w_nstate = r_state;
    w_tmo    = r_tmo;
    w_lock   = r_lock;
    w_rel    = r_rel;
    case (r_state)
      S_POR: begin
        if (w_por_s) begin
          w_nstate = S_INIT;
          w_tmo    = '0;
        end
      end
      S_INIT: begin
        if (w_init_ok) begin
          w_nstate = S_LOCK;
          w_lock   = '0;
        end else if (r_tmo == TMAX) begin
          w_nstate = S_ERR;
        end else begin
          w_tmo = r_tmo + TW'(1);
        end
      end
      S_LOCK: begin
        if (!w_init_ok) begin
          w_nstate = S_INIT;
          w_tmo    = '0;
          w_lock   = '0;
        end else if (!w_qual) begin
          w_lock = '0;
        end else if (r_lock == LMAX) begin
          w_nstate = S_HOLD;
          w_rel    = '0;
        end else begin
          w_lock = r_lock + LW'(1);
        end
      end
      S_HOLD: begin
        if (!w_qual) begin
          w_nstate = S_LOCK;
          w_lock   = '0;
        end else if (r_rel == RMAX) begin
          w_nstate = S_RUN;
        end else begin
          w_rel = r_rel + RW'(1);
        end
      end
      S_RUN: begin
        if (!w_init_ok) begin
          w_nstate = S_INIT;
          w_tmo    = '0;
          w_lock   = '0;
        end else if (!w_qual) begin
          w_nstate = S_LOCK;
          w_lock   = '0;
        end
      end
      S_ERR: begin
        w_nstate = S_ERR;
      end
      default: begin
        w_nstate = S_POR;
        w_tmo    = '0;
        w_lock   = '0;
        w_rel    = '0;
      end
    endcase
    // Power-on reset loss overrides everything except the sticky error.
    if ((r_state != S_ERR) && !w_por_s) begin
      w_nstate = S_POR;
      w_tmo    = '0;
      w_lock   = '0;
      w_rel    = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_POR;
      r_tmo   <= '0;
      r_lock  <= '0;
      r_rel   <= '0;
      r_rst_n <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_tmo   <= w_tmo;
      r_lock  <= w_lock;
      r_rel   <= w_rel;
      r_rst_n <= (w_nstate == S_RUN);
      r_err   <= r_err | (w_nstate == S_ERR);
    end
  end

  assign FABRIC_RESET_N = r_rst_n;
  assign INIT_ERR       = r_err;
  assign STATE          = r_state;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Directed bench: four sequencer builds share one set of inputs,
// expectations are queued per step and popped after each edge.
module tb_init_reset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic por_n = 1'b1;
  logic dev = 1'b1;
  logic sram = 1'b1;
  logic usram = 1'b1;
  logic xcvr = 1'b1;
  logic pll = 1'b1;
  logic ext_n = 1'b1;

  logic [3:0]      rstn;
  logic [3:0]      err;
  logic [3:0][2:0] st;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  // 0: defaults, 1: short timeout, 2: xcvr required, 3: sram not required
  init_reset_sequencer u_nom (
    .CLK(clk), .RST(rst), .FABRIC_POR_N(por_n),
    .DEVICE_INIT_DONE(dev), .SRAM_INIT_DONE(sram),
    .USRAM_INIT_DONE(usram), .XCVR_INIT_DONE(xcvr),
    .PLL_LOCK(pll), .EXT_RST_N(ext_n),
    .FABRIC_RESET_N(rstn[0]), .INIT_ERR(err[0]), .STATE(st[0])
  );

  init_reset_sequencer #(.TIMEOUT_CYCLES(32)) u_tmo (
    .CLK(clk), .RST(rst), .FABRIC_POR_N(por_n),
    .DEVICE_INIT_DONE(dev), .SRAM_INIT_DONE(sram),
    .USRAM_INIT_DONE(usram), .XCVR_INIT_DONE(xcvr),
    .PLL_LOCK(pll), .EXT_RST_N(ext_n),
    .FABRIC_RESET_N(rstn[1]), .INIT_ERR(err[1]), .STATE(st[1])
  );

  init_reset_sequencer #(.REQUIRE_XCVR(1)) u_xcvr (
    .CLK(clk), .RST(rst), .FABRIC_POR_N(por_n),
    .DEVICE_INIT_DONE(dev), .SRAM_INIT_DONE(sram),
    .USRAM_INIT_DONE(usram), .XCVR_INIT_DONE(xcvr),
    .PLL_LOCK(pll), .EXT_RST_N(ext_n),
    .FABRIC_RESET_N(rstn[2]), .INIT_ERR(err[2]), .STATE(st[2])
  );

  init_reset_sequencer #(.REQUIRE_SRAM(0)) u_nosram (
    .CLK(clk), .RST(rst), .FABRIC_POR_N(por_n),
    .DEVICE_INIT_DONE(dev), .SRAM_INIT_DONE(sram),
    .USRAM_INIT_DONE(usram), .XCVR_INIT_DONE(xcvr),
    .PLL_LOCK(pll), .EXT_RST_N(ext_n),
    .FABRIC_RESET_N(rstn[3]), .INIT_ERR(err[3]), .STATE(st[3])
  );

  function automatic logic [7:0] pk(input logic r, input logic e,
                                    input int s);
    logic [2:0] s3;
    s3 = 3'(s);
    return {3'b000, r, e, s3};
  endfunction

  function automatic logic [7:0] obs(input int sel);
    return {3'b000, rstn[sel], err[sel], st[sel]};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [7:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic pop_cmp(input logic [7:0] o);
    exp_t x;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=entry", o);
    end else begin
      x = sbq.pop_front();
      assert (o === x.exp) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", x.tag, o, x.exp);
      end
    end
  endtask

  // Hold RST for two edges; release lands just after "edge 0".
  task automatic do_reset();
    rst = 1'b1;
    step(2);
    push("reset_state", pk(0, 0, 0));
    pop_cmp(obs(0));
    rst = 1'b0;
  endtask

  task automatic all_ones();
    por_n = 1'b1; dev = 1'b1; sram = 1'b1; usram = 1'b1;
    xcvr = 1'b1; pll = 1'b1; ext_n = 1'b1;
  endtask

  // 2 sync edges, POR->INIT, INIT->LOCK, 4 lock, 16 hold.
  function automatic int nom_state(input int k);
    if (k < 3) return 0;
    if (k == 3) return 1;
    if (k < 8) return 2;
    if (k < 24) return 3;
    return 4;
  endfunction

  initial begin
    // Nominal bring-up, then loss of lock while running.
    all_ones();
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      push($sformatf("nom_e%0d", k), pk(k >= 24, 0, nom_state(k)));
      step(1);
      pop_cmp(obs(0));
    end
    step(2);
    push("run_stable_e26", pk(1, 0, 4));
    pop_cmp(obs(0));
    pll = 1'b0;
    for (int k = 27; k <= 28; k++) begin
      push($sformatf("lol_e%0d", k), pk(1, 0, 4));
      step(1);
      pop_cmp(obs(0));
    end
    push("lol_drop_e29", pk(0, 0, 2));
    step(1);
    pop_cmp(obs(0));
    push("lol_lock_e30", pk(0, 0, 2));
    step(1);
    pop_cmp(obs(0));
    pll = 1'b1;
    push("relock_e35", pk(0, 0, 2));
    step(5);
    pop_cmp(obs(0));
    push("relock_hold_e36", pk(0, 0, 3));
    step(1);
    pop_cmp(obs(0));
    push("relock_e51", pk(0, 0, 3));
    step(15);
    pop_cmp(obs(0));
    push("relock_run_e52", pk(1, 0, 4));
    step(1);
    pop_cmp(obs(0));

    // Lock glitch after three qualified cycles in S_LOCK.
    all_ones();
    do_reset();
    step(5);
    pll = 1'b0;
    step(1);
    pll = 1'b1;
    push("glitch_e7", pk(0, 0, 2));
    step(1);
    pop_cmp(obs(0));
    for (int k = 8; k <= 11; k++) begin
      push($sformatf("glitch_e%0d", k), pk(0, 0, 2));
      step(1);
      pop_cmp(obs(0));
    end
    push("glitch_hold_e12", pk(0, 0, 3));
    step(1);
    pop_cmp(obs(0));

    // POR drop while in S_HOLD, then full re-sequence.
    all_ones();
    do_reset();
    step(10);
    push("por_hold_e10", pk(0, 0, 3));
    pop_cmp(obs(0));
    por_n = 1'b0;
    push("por_e12", pk(0, 0, 3));
    step(2);
    pop_cmp(obs(0));
    push("por_drop_e13", pk(0, 0, 0));
    step(1);
    pop_cmp(obs(0));
    step(1);
    por_n = 1'b1;
    push("por_init_e17", pk(0, 0, 1));
    step(3);
    pop_cmp(obs(0));
    push("por_hold_e37", pk(0, 0, 3));
    step(20);
    pop_cmp(obs(0));
    push("por_run_e38", pk(1, 0, 4));
    step(1);
    pop_cmp(obs(0));

    // Timeout: 32 cycles in S_INIT, then sticky error.
    all_ones();
    dev = 1'b0;
    do_reset();
    push("tmo_init_e34", pk(0, 0, 1));
    step(34);
    pop_cmp(obs(1));
    push("tmo_err_e35", pk(0, 1, 5));
    step(1);
    pop_cmp(obs(1));
    dev = 1'b1;
    push("tmo_sticky_dev", pk(0, 1, 5));
    step(6);
    pop_cmp(obs(1));
    por_n = 1'b0;
    push("tmo_sticky_por0", pk(0, 1, 5));
    step(6);
    pop_cmp(obs(1));
    por_n = 1'b1;
    push("tmo_sticky_por1", pk(0, 1, 5));
    step(6);
    pop_cmp(obs(1));
    rst = 1'b1;
    push("tmo_rst_clear", pk(0, 0, 0));
    step(1);
    pop_cmp(obs(1));

    // XCVR required but not done; default build ignores it.
    all_ones();
    xcvr = 1'b0;
    do_reset();
    push("xcvr_nom_run_e24", pk(1, 0, 4));
    step(24);
    pop_cmp(obs(0));
    push("xcvr_stuck_e30", pk(0, 0, 1));
    step(6);
    pop_cmp(obs(2));

    // SRAM not required: SRAM_INIT_DONE low still reaches S_RUN.
    all_ones();
    sram = 1'b0;
    do_reset();
    push("nosram_e23", pk(0, 0, 3));
    step(23);
    pop_cmp(obs(3));
    push("nosram_run_e24", pk(1, 0, 4));
    step(1);
    pop_cmp(obs(3));
    push("sram_req_stuck_e24", pk(0, 0, 1));
    pop_cmp(obs(0));

    // Mid-run reset drops FABRIC_RESET_N on the next edge.
    rst = 1'b1;
    push("midrun_rst", pk(0, 0, 0));
    step(1);
    pop_cmp(obs(3));
    rst = 1'b0;

    if (sbq.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_left observed=%0d expected=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
